// File: rtl/digit_serial_subtractor.sv
// digit_serial_subtractor
//   Multi-cycle subtractor that computes diff = a - b one radix-2^DIGIT
//   digit per clock, least-significant digit first. NDIG = WIDTH/DIGIT
//   clock edges are spent in RUN. The borrow, overflow and zero flags are
//   produced together with the difference. diff and the flags hold the last
//   result until the next operation completes.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request; sampled only in IDLE
//   a, b         minuend / subtrahend; captured on the accepting edge
//   signed_mode  1: two's-complement overflow rule, 0: unsigned rule
//   busy         high while digits are being processed (RUN)
//   done         one-cycle pulse; diff and flags are valid
//   diff         a - b modulo 2^WIDTH
//   borrow       final digit borrow-out (a < b, unsigned)
//   overflow     signed or unsigned overflow, selected by signed_mode
//   zero         diff == 0
module digit_serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Working registers: operands shift right so the current digit always
  // sits in the low DIGIT bits.
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic             bin_reg;
  logic [CW-1:0]    cnt_reg;
  logic             a_msb_reg, b_msb_reg, sm_reg;

  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg, overflow_reg, zero_reg;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] res_next;
  logic             last_digit;
  logic             accept;
  logic             ovf_signed;

  // One digit subtraction, DIGIT+1 bits wide; the top bit is the borrow-out.
  assign dsum = {1'b0, a_reg[DIGIT-1:0]} - {1'b0, b_reg[DIGIT-1:0]}
              - {{DIGIT{1'b0}}, bin_reg};

  // New digit enters at the top; after NDIG shifts the digits are in place.
  generate
    if (NDIG == 1) begin : g_single
      assign res_next = dsum[DIGIT-1:0];
    end else begin : g_multi
      assign res_next = {dsum[DIGIT-1:0], res_reg[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign last_digit = (cnt_reg == CW'(NDIG - 1));
  assign accept     = (state_reg == IDLE) && start;
  assign ovf_signed = (a_msb_reg != b_msb_reg) && (res_next[WIDTH-1] != a_msb_reg);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      res_reg      <= '0;
      bin_reg      <= 1'b0;
      cnt_reg      <= '0;
      a_msb_reg    <= 1'b0;
      b_msb_reg    <= 1'b0;
      sm_reg       <= 1'b0;
      diff_reg     <= '0;
      borrow_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      a_msb_reg <= a[WIDTH-1];
      b_msb_reg <= b[WIDTH-1];
      sm_reg    <= signed_mode;
      res_reg   <= '0;
      bin_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      a_reg   <= a_reg >> DIGIT;
      b_reg   <= b_reg >> DIGIT;
      res_reg <= res_next;
      bin_reg <= dsum[DIGIT];
      cnt_reg <= cnt_reg + 1'b1;
      // Visible outputs change only when the whole word is finished.
      if (last_digit) begin
        diff_reg     <= res_next;
        borrow_reg   <= dsum[DIGIT];
        overflow_reg <= sm_reg ? ovf_signed : dsum[DIGIT];
        zero_reg     <= (res_next == '0);
      end
    end
  end

  assign diff     = diff_reg;
  assign borrow   = borrow_reg;
  assign overflow = overflow_reg;
  assign zero     = zero_reg;

endmodule
